// File: rtl/fifo_pkg.sv
// Shared constants for the stream FIFO family.
//   BUF_DEPTH  : depth of the show-ahead output prefetch buffer
//   ptr_width  : width of a binary read/write pointer (one wrap bit above
//                the RAM address)
package fifo_pkg;

  localparam int BUF_DEPTH = 2;

  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/fifomem.sv
// Dual-port RAM for the FIFO: synchronous write, 1-cycle registered read.
// A read and write to the same address in one cycle returns the old word.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re
//   rdata        : registered read data
module fifomem #(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                re,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  // Nonblocking read and write in one block give read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_stream_ctrl.sv
// Valid/ready stream FIFO: DEPTH-entry RAM plus a 2-entry show-ahead
// prefetch buffer, total capacity DEPTH+2.
//   clk, rst          : clock, asynchronous active-high reset
//   s_data/s_valid/s_ready : write side
//   m_data/m_valid/m_ready : read side (m_data is the head word)
//   count             : words held (RAM + in-flight read + buffer)
//   almost_full       : only with FIFO_STREAM_CTRL_ALMOST_FULL_EN defined;
//                       registered, high when count >= AF_LEVEL
module fifo_stream_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4,
  parameter int DATASIZE = 8
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
  ,
  parameter int AF_LEVEL = (2**ADDRSIZE) - 2
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATASIZE-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADDRSIZE:0]   count
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
  ,
  output logic                almost_full
`endif
);

  localparam int PW = ptr_width(ADDRSIZE);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [PW-1:0]       wptr, rptr;
  logic [CW-1:0]       occ, occ_nxt, after_pop;
  logic                rd_vld;      // RAM read data lands this cycle
  logic [DATASIZE-1:0] buf_q   [BUF_DEPTH];
  logic [DATASIZE-1:0] buf_nxt [BUF_DEPTH];
  logic [DATASIZE-1:0] rdata;
  logic                ram_full, ram_empty, push, pop, re;

  assign ram_empty = (wptr == rptr);
  assign ram_full  = (wptr[PW-1] != rptr[PW-1]) &&
                     (wptr[PW-2:0] == rptr[PW-2:0]);

  // s_ready depends only on the pointers, never on m_ready.
  assign s_ready = !ram_full;
  assign push    = s_valid && s_ready;

  // Read data that has just left the RAM is visible as the head at once,
  // which gives the 2-cycle write-to-m_valid latency.
  assign m_valid = (occ != '0) || rd_vld;
  assign m_data  = (occ != '0) ? buf_q[0] : (rd_vld ? rdata : '0);
  assign pop     = m_valid && m_ready;

  // Prefetch only while buffer plus in-flight word, after this cycle's pop,
  // leaves room; so occ + rd_vld never exceeds BUF_DEPTH.
  assign after_pop = occ + CW'(rd_vld) - CW'(pop);
  assign re        = !ram_empty && (after_pop < CW'(BUF_DEPTH));

  assign count = (wptr - rptr) + PW'(occ) + PW'(rd_vld);

  // Append arriving read data behind the buffered words, then shift out
  // the head on a pop.
  always_comb begin
    buf_nxt = buf_q;
    for (int i = 0; i < BUF_DEPTH; i++)
      if (rd_vld && occ == CW'(i)) buf_nxt[i] = rdata;
    if (pop)
      for (int i = 0; i < BUF_DEPTH - 1; i++) buf_nxt[i] = buf_nxt[i+1];
    occ_nxt = after_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      occ    <= '0;
      rd_vld <= 1'b0;
      buf_q  <= '{default: '0};
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (re)   rptr <= rptr + 1'b1;
      rd_vld <= re;
      occ    <= occ_nxt;
      buf_q  <= buf_nxt;
    end
  end

`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
  logic [PW-1:0] count_nxt;
  assign count_nxt = count + PW'(push) - PW'(pop);

  // Computed from next-cycle count so the flag lines up with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full <= 1'b0;
    else     almost_full <= (int'(count_nxt) >= AF_LEVEL);
  end
`endif

  fifomem #(
    .ADDRSIZE(ADDRSIZE),
    .DATASIZE(DATASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr[PW-2:0]),
    .wdata (s_data),
    .re    (re),
    .raddr (rptr[PW-2:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Self-checking bench for fifo_stream_ctrl (ADDRSIZE=4, DATASIZE=8).
// Reference model: a queue of accepted words with their acceptance cycle.
// A word is visible at the head two cycles after it was accepted.
module tb_fifo_stream_ctrl;

  localparam int AS    = 4;
  localparam int DS    = 8;
  localparam int DEPTH = 16;
  localparam int CAP   = DEPTH + 2;
  localparam int AFL   = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [DS-1:0] s_data;
  logic          s_valid, s_ready;
  logic [DS-1:0] m_data;
  logic          m_valid, m_ready;
  logic [AS:0]   count;
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
  logic          almost_full;
`endif

  always #5 clk = ~clk;

  fifo_stream_ctrl #(
    .ADDRSIZE(AS),
    .DATASIZE(DS)
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
    ,
    .AF_LEVEL(AFL)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .count   (count)
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
    ,
    .almost_full (almost_full)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  int n_push = 0;
  logic [DS-1:0] q_d[$];
  int            q_t[$];
  logic [DS-1:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model before the edge,
  // then apply the handshakes the DUT saw to the model.
  task automatic cyc();
    bit ev, push, pop;
    @(negedge clk);
    ev = (q_d.size() > 0) && ((cyc_n - q_t[0]) >= 2);
    chk("m_valid", 32'(m_valid), 32'(ev));
    if (ev) chk("m_data", 32'(m_data), 32'(q_d[0]));
    chk("count", 32'(count), 32'(q_d.size()));
    if (q_d.size() < DEPTH) chk("s_ready_open", 32'(s_ready), 32'd1);
    if (q_d.size() == CAP)  chk("s_ready_full", 32'(s_ready), 32'd0);
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full), 32'(q_d.size() >= AFL));
`endif
    push = s_valid && s_ready;
    pop  = m_valid && m_ready && (q_d.size() > 0);
    @(posedge clk);
    if (pop) begin
      popped.push_back(q_d[0]);
      void'(q_d.pop_front());
      void'(q_t.pop_front());
    end
    if (push) begin
      q_d.push_back(s_data);
      q_t.push_back(cyc_n);
      n_push++;
    end
    cyc_n++;
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 80 && q_d.size() > 0; i++) cyc();
    repeat (2) cyc();
    chk("drain_done", 32'(q_d.size()), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int c5, start;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;

    // Reset values
    #12;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    chk("rst_count",   32'(count),   32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single word into empty FIFO, visible 2 cycles after handshake
    s_valid = 1'b1; s_data = 8'hA5;
    cyc();
    s_valid = 1'b0;
    cyc();
    cyc();
    chk("t030_valid", 32'(m_valid), 32'd1);
    chk("t030_data",  32'(m_data),  32'hA5);
    chk("t030_count", 32'(count),   32'd1);
    drain();

    // Fill to capacity with m_ready low
    popped.delete();
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = DS'(i);
      cyc();
    end
    s_valid = 1'b0;
    chk("t031_accepted", 32'(q_d.size()), 32'd18);
    chk("t031_count",    32'(count),      32'd18);
    chk("t031_s_ready",  32'(s_ready),    32'd0);
    drain();
    chk("t031_drained", 32'(popped.size()), 32'd18);
    for (int i = 0; i < 18 && i < popped.size(); i++)
      chk("t031_order", 32'(popped[i]), 32'(i));

    // Continuous streaming
    c5 = 0;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 5) begin popped.delete(); c5 = int'(count); end
      s_data = DS'(i + 8'h40);
      cyc();
    end
    chk("t032_rate",  32'(popped.size()), 32'd95);
    chk("t032_count", 32'(count), 32'(c5));
    drain();

    // Random traffic, 40 words
    popped.delete();
    start = n_push;
    for (int i = 0; i < 2000 && (n_push - start) < 40; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = DS'($urandom);
      m_ready = ($urandom_range(0, 2) == 0);
      cyc();
    end
    chk("t033_sent", 32'(n_push - start), 32'd40);
    drain();
    chk("t033_recv", 32'(popped.size()), 32'd40);

    // Reset mid-transfer with a read in flight
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = DS'(8'h50 + i);
      cyc();
    end
    s_valid = 1'b0;
    cyc(); cyc();
    s_valid = 1'b1; s_data = 8'h57; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0; m_ready = 1'b0;
    chk("t034_pre_count", 32'(count), 32'd7);
    #2 rst = 1'b1;
    #1;
    chk("t034_m_valid", 32'(m_valid), 32'd0);
    chk("t034_count",   32'(count),   32'd0);
    chk("t034_s_ready", 32'(s_ready), 32'd1);
    q_d.delete(); q_t.delete();
    @(posedge clk); #1;
    chk("t034_hold_count", 32'(count), 32'd0);
    rst = 1'b0;
    s_valid = 1'b1; s_data = 8'hC3;
    cyc();
    popped.delete();
    drain();
    chk("t034_first", popped.size() > 0 ? 32'(popped[0]) : 32'hDEAD, 32'hC3);

`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
    // almost_full threshold crossing
    for (int i = 0; i < AFL; i++) begin
      s_valid = 1'b1; s_data = DS'(i);
      cyc();
      if (i == AFL - 2) chk("t035_below", 32'(almost_full), 32'd0);
    end
    s_valid = 1'b0;
    chk("t035_rise", 32'(almost_full), 32'd1);
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("t035_fall", 32'(almost_full), 32'd0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_stream_ctrl.md
FIFO_STREAM_CTRL -- requirements
Module: fifo_stream_ctrl

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: RAM address width; DEPTH = 2**ADDRSIZE; legal range 2..12.
REQ-002 SHALL have parameter DATASIZE, default 8: word width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_data  input  DATASIZE  write-side word.
REQ-006 SHALL have port s_valid  input  1  write-side word present.
REQ-007 SHALL have port s_ready  output  1  write side accepts; transfer when s_valid && s_ready.
REQ-008 SHALL have port m_data  output  DATASIZE  head word, show-ahead.
REQ-009 SHALL have port m_valid  output  1  m_data holds the oldest unread word.
REQ-010 SHALL have port m_ready  input  1  consumer pops; pop when m_valid && m_ready.
REQ-011 SHALL have port count  output  ADDRSIZE+1  total words held: RAM + in-flight read + output buffer.

Function
REQ-012 SHALL store words in a DEPTH-entry RAM with 1-cycle registered read and read-before-write on an address collision.
REQ-013 SHALL use binary write and read pointers of ADDRSIZE+1 bits; RAM full = MSBs differ and low bits equal; RAM empty = pointers equal; wrap modulo 2**(ADDRSIZE+1).
REQ-014 SHALL drive s_ready = !RAM-full from registered state only, with no combinational path from m_ready.
REQ-015 SHALL hold a 2-entry output prefetch buffer; a RAM read issues when RAM is non-empty and buffer occupancy + in-flight read, after this cycle's pop, is < 2.
REQ-016 SHALL give total capacity DEPTH+2 words.
REQ-017 SHALL raise m_valid exactly 2 cycles after the handshake cycle of a write into a completely empty FIFO.
REQ-018 SHALL sustain 1 word/cycle in and out when s_valid and m_ready are held high.
REQ-019 SHALL deliver words in strict arrival order with no loss or duplication.
REQ-020 SHALL keep m_data stable while m_valid && !m_ready.
REQ-021 SHALL apply a simultaneous push and pop as net count change 0.
REQ-022 SHALL ignore s_valid while s_ready is low, and m_ready while m_valid is low.

Reset
REQ-023 SHALL, on rst assertion at any time including mid-transfer, asynchronously clear the pointers, the buffer and the in-flight flag, and discard all contents.
REQ-024 SHALL drive reset values: s_ready=1, m_valid=0, m_data=0, count=0.
REQ-025 SHALL accept its first write on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with FIFO_STREAM_CTRL_ALMOST_FULL_EN defined, add parameter AF_LEVEL (default DEPTH-2) and registered output almost_full (1 bit), high when count >= AF_LEVEL; reset value 0.
REQ-027 SHALL, with FIFO_STREAM_CTRL_ALMOST_FULL_EN undefined, have neither the AF_LEVEL parameter nor the almost_full port, and all other behaviour SHALL be identical.

Structure
REQ-028 SHALL take its shared constants from package fifo_pkg: pointer-width function, and the output-buffer depth constant BUF_DEPTH=2.
REQ-029 SHALL instantiate the existing fifomem RAM as its only sub-module, with ADDRSIZE and DATASIZE passed through; pointer, prefetch and count logic SHALL reside in fifo_stream_ctrl.

Verification
REQ-030 SHALL cover: ADDRSIZE=4, write 0xA5 into empty FIFO with m_ready=0 -> m_valid high 2 cycles later, m_data=0xA5, count=1.
REQ-031 SHALL cover: m_ready=0, 20 writes of 0..19 attempted -> 18 accepted, s_ready low after the 18th, count=18; drain -> words 0..17 in order.
REQ-032 SHALL cover: s_valid=1 and m_ready=1 continuous for 100 cycles -> after warm-up, 1 word/cycle out, count constant, ordered output.
REQ-033 SHALL cover: 40 words with random s_valid/m_ready and pointer wrap past 32 -> scoreboard match, no loss or duplicate.
REQ-034 SHALL cover: rst pulsed with count=7 and a read in flight -> next cycle m_valid=0, count=0, s_ready=1; next write is the next word read out.
REQ-035 SHALL cover: FIFO_STREAM_CTRL_ALMOST_FULL_EN defined, AF_LEVEL=14 -> almost_full rises as count reaches 14 and falls when count drops to 13.
